// File: rtl/jtbubl_sndcomm_pkg.sv
// Register offsets and status bit positions shared by the sound mailbox.
package jtbubl_sndcomm_pkg;
   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STAT   = 2'd1;
   localparam logic [1:0] ADDR_NMIEN  = 2'd2;
   localparam logic [1:0] ADDR_NMIDIS = 2'd3;
   localparam logic [1:0] ADDR_SRST   = 2'd3;

   localparam int ST_CMD   = 0;
   localparam int ST_REPLY = 1;
   localparam int ST_OVF   = 2;
endpackage

// File: rtl/jtbubl_sndcomm_edge.sv
// Rising-edge detector for a level chip-select; one pulse per assertion.
// Output is combinational from cs and the registered previous level.
module jtbubl_sndcomm_edge (
   input  logic clk24,
   input  logic rst,
   input  logic din,
   output logic rise
);
   logic last;

   always_ff @(posedge clk24) begin
      if (rst) last <= 1'b0;
      else     last <= din;
   end

   assign rise = din & ~last;
endmodule

// File: rtl/jtbubl_sndcomm.sv
// Main/sound Z80 mailbox: command latch, optional reply latch (JTBUBL_SNDREPLY_EN), NMI and sound reset.
// Registers update on the cs rising-edge cycle; snd_nmi_n follows one cycle later. No backpressure.
module jtbubl_sndcomm
   import jtbubl_sndcomm_pkg::*;
(
   input  logic       clk24,
   input  logic       rst,
   input  logic       main_cs,
   input  logic       main_rnw,
   input  logic [1:0] main_addr,
   input  logic [7:0] main_dout,
   output logic [7:0] main_din,
   input  logic       snd_cs,
   input  logic       snd_rnw,
   input  logic [1:0] snd_addr,
   input  logic [7:0] snd_dout,
   output logic [7:0] snd_din,
   output logic       snd_nmi_n,
   output logic       snd_rst
);
   logic       main_rise, snd_rise, snd_ev;
   logic       m_wr_data, m_rd_data, m_rd_stat, m_wr_srst;
   logic       s_rd_data, s_wr_nmien, s_wr_nmidis;
   logic [7:0] cmd_latch;
   logic       cmd_pend, ovf, nmi_en, snd_rst_r;
   logic       reply_pend;
   logic [7:0] main_stat, snd_stat;

   jtbubl_sndcomm_edge u_main_edge (
      .clk24 ( clk24     ),
      .rst   ( rst       ),
      .din   ( main_cs   ),
      .rise  ( main_rise )
   );

   jtbubl_sndcomm_edge u_snd_edge (
      .clk24 ( clk24    ),
      .rst   ( rst      ),
      .din   ( snd_cs   ),
      .rise  ( snd_rise )
   );

   // The sound CPU is held in reset, so its bus activity is meaningless.
   assign snd_ev      = snd_rise & ~snd_rst_r;

   assign m_wr_data   = main_rise & ~main_rnw & (main_addr == ADDR_DATA);
   assign m_rd_data   = main_rise &  main_rnw & (main_addr == ADDR_DATA);
   assign m_rd_stat   = main_rise &  main_rnw & (main_addr == ADDR_STAT);
   assign m_wr_srst   = main_rise & ~main_rnw & (main_addr == ADDR_SRST);
   assign s_rd_data   = snd_ev &  snd_rnw & (snd_addr == ADDR_DATA);
   assign s_wr_nmien  = snd_ev & ~snd_rnw & (snd_addr == ADDR_NMIEN);
   assign s_wr_nmidis = snd_ev & ~snd_rnw & (snd_addr == ADDR_NMIDIS);

   assign snd_rst = snd_rst_r;

   always_ff @(posedge clk24) begin
      if (rst) begin
         cmd_latch <= 8'h00;
         cmd_pend  <= 1'b0;
         ovf       <= 1'b0;
         nmi_en    <= 1'b0;
         snd_rst_r <= 1'b0;
         snd_nmi_n <= 1'b1;
      end else begin
         snd_nmi_n <= ~(cmd_pend & nmi_en);
         // A write racing a sound read wins and is not an overflow.
         if (m_wr_data) begin
            cmd_latch <= main_dout;
            cmd_pend  <= 1'b1;
            if (cmd_pend && !s_rd_data) ovf <= 1'b1;
         end else if (s_rd_data) begin
            cmd_pend  <= 1'b0;
         end
         if (m_rd_stat) ovf       <= 1'b0;
         if (m_wr_srst) snd_rst_r <= main_dout[0];
         if (snd_rst_r)        nmi_en <= 1'b0;
         else if (s_wr_nmien)  nmi_en <= 1'b1;
         else if (s_wr_nmidis) nmi_en <= 1'b0;
      end
   end

`ifdef JTBUBL_SNDREPLY_EN
   logic [7:0] reply_latch;
   logic       s_wr_data;

   assign s_wr_data = snd_ev & ~snd_rnw & (snd_addr == ADDR_DATA);

   always_ff @(posedge clk24) begin
      if (rst || snd_rst_r) begin
         reply_latch <= 8'h00;
         reply_pend  <= 1'b0;
      end else if (s_wr_data) begin
         reply_latch <= snd_dout;
         reply_pend  <= 1'b1;
      end else if (m_rd_data) begin
         reply_pend  <= 1'b0;
      end
   end
`else
   logic unused_reply;
   assign unused_reply = ^{snd_dout, m_rd_data};
   assign reply_pend   = 1'b0;
`endif

   always_comb begin
      main_stat           = 8'h00;
      main_stat[ST_CMD]   = cmd_pend;
      main_stat[ST_REPLY] = reply_pend;
      main_stat[ST_OVF]   = ovf;
      snd_stat            = 8'h00;
      snd_stat[ST_CMD]    = cmd_pend;
      snd_stat[ST_REPLY]  = reply_pend;
   end

   always_comb begin
      main_din = 8'hFF;
      if (main_cs && main_rnw) begin
`ifdef JTBUBL_SNDREPLY_EN
         if (main_addr == ADDR_DATA) main_din = reply_latch;
`endif
         if (main_addr == ADDR_STAT) main_din = main_stat;
      end
   end

   always_comb begin
      snd_din = 8'hFF;
      if (snd_cs && snd_rnw) begin
         if (snd_addr == ADDR_DATA) snd_din = cmd_latch;
         if (snd_addr == ADDR_STAT) snd_din = snd_stat;
      end
   end
endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Scoreboard bench for the sound mailbox: stimulus queues expected read data and
// signal probes; a monitor pops and compares when the DUT presents them.
`timescale 1ns/1ps
module tb_jtbubl_sndcomm;
   logic       clk24 = 1'b0;
   logic       rst   = 1'b1;
   logic       main_cs = 1'b0, main_rnw = 1'b1;
   logic [1:0] main_addr = 2'd0;
   logic [7:0] main_dout = 8'h00;
   logic [7:0] main_din;
   logic       snd_cs = 1'b0, snd_rnw = 1'b1;
   logic [1:0] snd_addr = 2'd0;
   logic [7:0] snd_dout = 8'h00;
   logic [7:0] snd_din;
   logic       snd_nmi_n, snd_rst;

   typedef struct {
      string      name;
      logic [7:0] exp;
      logic       sel;
   } exp_t;

   exp_t main_q[$];
   exp_t snd_q[$];
   exp_t sig_q[$];
   logic probe_req = 1'b0;
   logic done      = 1'b0;
   int   n_checks  = 0;
   int   n_fail    = 0;

   jtbubl_sndcomm dut (
      .clk24     ( clk24     ),
      .rst       ( rst       ),
      .main_cs   ( main_cs   ),
      .main_rnw  ( main_rnw  ),
      .main_addr ( main_addr ),
      .main_dout ( main_dout ),
      .main_din  ( main_din  ),
      .snd_cs    ( snd_cs    ),
      .snd_rnw   ( snd_rnw   ),
      .snd_addr  ( snd_addr  ),
      .snd_dout  ( snd_dout  ),
      .snd_din   ( snd_din   ),
      .snd_nmi_n ( snd_nmi_n ),
      .snd_rst   ( snd_rst   )
   );

   always #5 clk24 = ~clk24;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   initial begin : monitor
      logic m_prev, s_prev;
      exp_t e;
      m_prev = 1'b0;
      s_prev = 1'b0;
      forever begin
         @(negedge clk24);
         if (main_cs && main_rnw && !m_prev) begin
            if (main_q.size() == 0) chk("unexpected main read", main_din, 8'hxx);
            else begin
               e = main_q.pop_front();
               chk(e.name, main_din, e.exp);
            end
         end
         if (snd_cs && snd_rnw && !s_prev) begin
            if (snd_q.size() == 0) chk("unexpected snd read", snd_din, 8'hxx);
            else begin
               e = snd_q.pop_front();
               chk(e.name, snd_din, e.exp);
            end
         end
         if (probe_req && sig_q.size() != 0) begin
            e = sig_q.pop_front();
            chk(e.name, e.sel ? {7'd0, snd_rst} : {7'd0, snd_nmi_n}, e.exp);
         end
         m_prev = main_cs;
         s_prev = snd_cs;
         if (done) begin
            chk("main queue drained", 8'(main_q.size()), 8'd0);
            chk("snd queue drained",  8'(snd_q.size()),  8'd0);
            chk("probe queue drained", 8'(sig_q.size()), 8'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk24);
      #1;
   endtask

   task automatic main_acc(input logic rnw, input logic [1:0] a, input logic [7:0] d, input int hold);
      main_cs = 1'b1; main_rnw = rnw; main_addr = a; main_dout = d;
      idle(hold);
      main_cs = 1'b0; main_rnw = 1'b1;
      idle(1);
   endtask

   task automatic snd_acc(input logic rnw, input logic [1:0] a, input logic [7:0] d, input int hold);
      snd_cs = 1'b1; snd_rnw = rnw; snd_addr = a; snd_dout = d;
      idle(hold);
      snd_cs = 1'b0; snd_rnw = 1'b1;
      idle(1);
   endtask

   task automatic main_rd(input logic [1:0] a, input logic [7:0] exp, input string name);
      main_q.push_back('{name, exp, 1'b0});
      main_acc(1'b1, a, 8'h00, 1);
   endtask

   task automatic snd_rd(input logic [1:0] a, input logic [7:0] exp, input string name);
      snd_q.push_back('{name, exp, 1'b0});
      snd_acc(1'b1, a, 8'h00, 1);
   endtask

   // sel 0 = snd_nmi_n, sel 1 = snd_rst; consumes one clock.
   task automatic probe(input logic sel, input logic exp, input string name);
      sig_q.push_back('{name, {7'd0, exp}, sel});
      probe_req = 1'b1;
      @(negedge clk24);
      #1 probe_req = 1'b0;
      idle(1);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      idle(3);
      rst = 1'b0;
      probe(1'b0, 1'b1, "reset nmi_n");
      probe(1'b1, 1'b0, "reset snd_rst");
      main_rd(2'd1, 8'h00, "reset main status");
      snd_rd(2'd1, 8'h00, "reset snd status");

      // Command delivery with NMI enabled after the write.
      main_acc(1'b0, 2'd0, 8'h5A, 1);
      main_rd(2'd1, 8'h01, "cmd_pend after write");
      probe(1'b0, 1'b1, "nmi_n with nmi_en=0");
      snd_cs = 1'b1; snd_rnw = 1'b0; snd_addr = 2'd2;
      probe(1'b0, 1'b1, "nmi_n at enable edge");
      snd_cs = 1'b0; snd_rnw = 1'b1;
      probe(1'b0, 1'b1, "nmi_n 1 cycle after enable");
      probe(1'b0, 1'b0, "nmi_n 2 cycles after enable");
      snd_rd(2'd0, 8'h5A, "snd reads cmd 0x5A");
      probe(1'b0, 1'b1, "nmi_n released after read");
      main_rd(2'd1, 8'h00, "status after cmd read");

      // Long chip-select yields a single event.
      main_acc(1'b0, 2'd0, 8'h11, 40);
      main_rd(2'd1, 8'h01, "held cs single event");
      snd_rd(2'd0, 8'h11, "snd reads 0x11");

      // Overflow and sticky clear on status read.
      main_acc(1'b0, 2'd0, 8'h01, 1);
      main_acc(1'b0, 2'd0, 8'h02, 1);
      main_rd(2'd1, 8'h05, "status with ovf");
      main_rd(2'd1, 8'h01, "status ovf cleared");
      snd_rd(2'd0, 8'h02, "snd reads last cmd 0x02");
      main_rd(2'd1, 8'h00, "status idle");

      // Reply path.
      snd_acc(1'b0, 2'd0, 8'hC3, 1);
`ifdef JTBUBL_SNDREPLY_EN
      main_rd(2'd1, 8'h02, "reply_pend set");
      main_rd(2'd0, 8'hC3, "main reads reply");
`else
      main_rd(2'd1, 8'h00, "no reply_pend");
      main_rd(2'd0, 8'hFF, "no reply latch");
`endif
      main_rd(2'd1, 8'h00, "status after reply read");

      // Unmapped reads.
      main_rd(2'd2, 8'hFF, "main addr2 read");
      snd_rd(2'd3, 8'hFF, "snd addr3 read");

      // Simultaneous main write and sound read at addr 0.
      main_cs = 1'b1; main_rnw = 1'b0; main_addr = 2'd0; main_dout = 8'h77;
      snd_q.push_back('{"simultaneous snd read old", 8'h02, 1'b0});
      snd_cs = 1'b1; snd_rnw = 1'b1; snd_addr = 2'd0;
      idle(1);
      main_cs = 1'b0; main_rnw = 1'b1; snd_cs = 1'b0;
      idle(1);
      main_rd(2'd1, 8'h01, "write wins over read");
      snd_rd(2'd0, 8'h77, "snd reads 0x77");

      // Sound reset: nmi_en cleared, sound events ignored, command kept.
      main_acc(1'b0, 2'd0, 8'h33, 1);
      probe(1'b0, 1'b0, "nmi_n low before reset");
      main_acc(1'b0, 2'd3, 8'h01, 1);
      probe(1'b1, 1'b1, "snd_rst asserted");
      idle(1);
      probe(1'b0, 1'b1, "nmi_n high in sound reset");
      snd_acc(1'b0, 2'd2, 8'h00, 1);
      snd_acc(1'b0, 2'd0, 8'h99, 1);
      idle(2);
      probe(1'b0, 1'b1, "nmi enable ignored in reset");
      main_rd(2'd1, 8'h01, "cmd kept, reply ignored in reset");
      main_acc(1'b0, 2'd3, 8'h00, 1);
      probe(1'b1, 1'b0, "snd_rst released");
      snd_rd(2'd0, 8'h33, "cmd delivered after reset");

      // Reset asserted mid-access: held cs gives one event after release.
      rst = 1'b1;
      main_cs = 1'b1; main_rnw = 1'b0; main_addr = 2'd0; main_dout = 8'h44;
      idle(2);
      rst = 1'b0;
      idle(3);
      main_cs = 1'b0; main_rnw = 1'b1;
      idle(1);
      main_rd(2'd1, 8'h01, "event after reset release");
      probe(1'b0, 1'b1, "nmi_n after core reset");
      snd_rd(2'd0, 8'h44, "snd reads 0x44");

      idle(2);
      done = 1'b1;
   end
endmodule
